mem_block_arbiter: RTL

Two-port round-robin arbiter and access sequencer in front of the 4K x 32 block memory (`mem_block`), sharing it between instruction fetch (port 0) and data load/store (port 1). It accepts one request per grant, drives the memory's address, data and enable lines for exactly one cycle, and returns read data or a write acknowledge to the winning requester. It sits between the pipeline's fetch/memory stages and the memory instance.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 20 ++
 rtl/mem_block_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the block-memory arbiter
package mem_arb_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 32;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // On a tie the port that did not win last time goes first.
  always_comb begin
    win = 2'b00;
    if (req == 2'b11) begin
      win = (last == PORT_DM) ? 2'b01 : 2'b10;
    end else begin
      win = req;
    end
  end

endmodule

// File: rtl/mem_block_arbiter.sv
// rtl/mem_block_arbiter.sv - round-robin arbiter and one-cycle access sequencer for mem_block
module mem_block_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_da,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_doa
);

  arb_state_t    state_q, state_d;
  logic          last_q;
  logic          port_q;
  logic          we_q;
  logic [AW-1:0] mem_da_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_read_q, mem_write_q;

  logic [1:0]    win;
  logic          win_idx;
  logic          grant;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  assign grant     = (state_q == IDLE) && (|req);
  assign win_idx   = win[1];
  assign win_we    = we[win_idx];
  assign win_addr  = (win_idx == PORT_DM) ? addr1 : addr0;
  assign win_wdata = (win_idx == PORT_DM) ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write ack shares the ACCESS cycle; read ack waits one cycle for mem_doa.
  always_comb begin
    gnt = 2'b00;
    ack = 2'b00;
    if (grant) gnt = win;
    case (state_q)
      ACCESS:  if (we_q) ack[port_q] = 1'b1;
      RESP:    ack[port_q] = 1'b1;
      default: ack = 2'b00;
    endcase
  end

  // Request fields are captured only at grant so late input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= PORT_DM;
      port_q      <= PORT_IF;
      we_q        <= 1'b0;
      mem_da_q    <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      mem_read_q  <= grant && !win_we;
      mem_write_q <= grant && win_we;
      if (grant) begin
        last_q      <= win_idx;
        port_q      <= win_idx;
        we_q        <= win_we;
        mem_da_q    <= win_addr;
        mem_wdata_q <= win_wdata;
      end
    end
  end

  assign mem_da    = mem_da_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign rdata     = mem_doa;

endmodule
